// File: rtl/mem_wb_seg_reg.sv
// ----------------------------------------------------------------------------
// mem_wb_seg_reg
//   MEM/WB pipeline segment register for the five-stage RISC-V core.
//   Registers the MEM-stage control/result fields into WB with stall (en=0)
//   and flush (clear) handling, forwards the MEM access to the data cache,
//   aligns the one-cycle-latency cache read data with the WB fields, raises
//   a pipeline stall request while the cache reports a miss, and keeps
//   per-type (load/store) hit/miss counters counted once per access episode.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   en, clear                     segment enable (0 = hold), synchronous flush
//   addr_m, wdata_m, we_m         MEM-stage address, store data, byte enables
//   mem_to_reg_m                  load request
//   result_m, rd_m, reg_write_m   ALU result, destination, write type
//   result_w, rd_w, reg_write_w   registered WB fields
//   mem_to_reg_w, byte_sel_w      registered load flag and address low bits
//   rd_data_w                     load data presented to WB
//   cache_addr/rd_req/wr_req/wr_data   data-cache request (combinational)
//   cache_rd_data, cache_miss     data-cache response
//   stall_req                     pipeline stall request while a miss is open
//   cnt_clr                       synchronous clear of the counters
//   ld_hit_cnt, ld_miss_cnt, st_hit_cnt, st_miss_cnt   saturating counters
// ----------------------------------------------------------------------------
module mem_wb_seg_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int BSEL_W = (BE_W > 1) ? $clog2(BE_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic [BE_W-1:0]   we_m,
    input  logic              mem_to_reg_m,
    input  logic [DATA_W-1:0] result_m,
    input  logic [REG_W-1:0]  rd_m,
    input  logic [2:0]        reg_write_m,
    output logic [DATA_W-1:0] result_w,
    output logic [REG_W-1:0]  rd_w,
    output logic [2:0]        reg_write_w,
    output logic              mem_to_reg_w,
    output logic [BSEL_W-1:0] byte_sel_w,
    output logic [DATA_W-1:0] rd_data_w,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_rd_req,
    output logic              cache_wr_req,
    output logic [DATA_W-1:0] cache_wr_data,
    input  logic [DATA_W-1:0] cache_rd_data,
    input  logic              cache_miss,
    output logic              stall_req,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ld_hit_cnt,
    output logic [CNT_W-1:0]  ld_miss_cnt,
    output logic [CNT_W-1:0]  st_hit_cnt,
    output logic [CNT_W-1:0]  st_miss_cnt
);

    // ------------------------------------------------------------------
    // Cache request interface and stall request (no added latency)
    // ------------------------------------------------------------------
    logic access_active;

    assign cache_addr    = addr_m;
    assign cache_rd_req  = mem_to_reg_m;
    assign cache_wr_req  = |we_m;
    assign cache_wr_data = wdata_m;
    assign access_active = cache_rd_req | cache_wr_req;
    assign stall_req     = access_active & cache_miss;

    // ------------------------------------------------------------------
    // Segment register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_w     <= '0;
            rd_w         <= '0;
            reg_write_w  <= '0;
            mem_to_reg_w <= 1'b0;
            byte_sel_w   <= '0;
        end else if (en) begin
            if (clear) begin
                result_w     <= '0;
                rd_w         <= '0;
                reg_write_w  <= '0;
                mem_to_reg_w <= 1'b0;
                byte_sel_w   <= '0;
            end else begin
                result_w     <= result_m;
                rd_w         <= rd_m;
                reg_write_w  <= reg_write_m;
                mem_to_reg_w <= mem_to_reg_m;
                byte_sel_w   <= addr_m[BSEL_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-data path
    // The cache data arrives one cycle after the request, i.e. in the same
    // cycle the load sits in WB. If the segment was stalled on the last
    // edge, the cache may already have moved on, so replay the value WB
    // saw before the stall; if it was flushed, present zero.
    // ------------------------------------------------------------------
    logic              stall_ff;
    logic              clear_ff;
    logic [DATA_W-1:0] rd_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_ff <= 1'b0;
            clear_ff <= 1'b0;
            rd_old   <= '0;
        end else begin
            stall_ff <= ~en;
            clear_ff <= clear & en;
            rd_old   <= rd_data_w;
        end
    end

    assign rd_data_w = stall_ff ? rd_old :
                       clear_ff ? '0     : cache_rd_data;

    // ------------------------------------------------------------------
    // Access episode detection
    // A stalled access stays in MEM with the same address and type for
    // several cycles; it must be counted once. An access separated by an
    // idle cycle, or one changing address or type, starts a new episode.
    // ------------------------------------------------------------------
    logic              prev_active;
    logic [ADDR_W-1:0] last_addr;
    logic              last_is_ld;
    logic              new_episode;

    assign new_episode = access_active &
                         (~prev_active | (addr_m != last_addr) |
                          (cache_rd_req != last_is_ld));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_active <= 1'b0;
            last_addr   <= '0;
            last_is_ld  <= 1'b0;
        end else begin
            prev_active <= access_active;
            if (access_active) begin
                last_addr  <= addr_m;
                last_is_ld <= cache_rd_req;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating, clear has priority)
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_hit_cnt  <= '0;
            ld_miss_cnt <= '0;
            st_hit_cnt  <= '0;
            st_miss_cnt <= '0;
        end else if (cnt_clr) begin
            ld_hit_cnt  <= '0;
            ld_miss_cnt <= '0;
            st_hit_cnt  <= '0;
            st_miss_cnt <= '0;
        end else if (new_episode) begin
            // Load wins when a load and a store are requested together.
            if (cache_rd_req) begin
                if (cache_miss) ld_miss_cnt <= sat_inc(ld_miss_cnt);
                else            ld_hit_cnt  <= sat_inc(ld_hit_cnt);
            end else begin
                if (cache_miss) st_miss_cnt <= sat_inc(st_miss_cnt);
                else            st_hit_cnt  <= sat_inc(st_hit_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_seg_reg.sv
module tb_mem_wb_seg_reg;

    logic clk;
    logic rst_n;

    // Main instance: DATA_W=32, CNT_W=32
    logic        en, clear, mem_to_reg_m, cache_miss, cnt_clr;
    logic [31:0] addr_m, wdata_m, result_m, cache_rd_data;
    logic [3:0]  we_m;
    logic [4:0]  rd_m;
    logic [2:0]  reg_write_m;
    logic [31:0] result_w, rd_data_w, cache_addr, cache_wr_data;
    logic [4:0]  rd_w;
    logic [2:0]  reg_write_w;
    logic        mem_to_reg_w, cache_rd_req, cache_wr_req, stall_req;
    logic [1:0]  byte_sel_w;
    logic [31:0] ld_hit_cnt, ld_miss_cnt, st_hit_cnt, st_miss_cnt;

    // Wide instance: DATA_W=64, CNT_W=4
    logic        w_mem_to_reg_m, w_cache_miss, w_cnt_clr;
    logic [31:0] w_addr_m;
    logic [63:0] w_wdata_m, w_result_m, w_cache_rd_data;
    logic [7:0]  w_we_m;
    logic [63:0] w_result_w, w_rd_data_w, w_cache_wr_data;
    logic [31:0] w_cache_addr;
    logic [4:0]  w_rd_w;
    logic [2:0]  w_reg_write_w;
    logic        w_mem_to_reg_w, w_cache_rd_req, w_cache_wr_req, w_stall_req;
    logic [2:0]  w_byte_sel_w;
    logic [3:0]  w_ld_hit_cnt, w_ld_miss_cnt, w_st_hit_cnt, w_st_miss_cnt;

    int checks = 0;
    int errors = 0;
    int stall_cycles;

    mem_wb_seg_reg u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .addr_m(addr_m), .wdata_m(wdata_m), .we_m(we_m),
        .mem_to_reg_m(mem_to_reg_m), .result_m(result_m), .rd_m(rd_m),
        .reg_write_m(reg_write_m), .result_w(result_w), .rd_w(rd_w),
        .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
        .byte_sel_w(byte_sel_w), .rd_data_w(rd_data_w),
        .cache_addr(cache_addr), .cache_rd_req(cache_rd_req),
        .cache_wr_req(cache_wr_req), .cache_wr_data(cache_wr_data),
        .cache_rd_data(cache_rd_data), .cache_miss(cache_miss),
        .stall_req(stall_req), .cnt_clr(cnt_clr),
        .ld_hit_cnt(ld_hit_cnt), .ld_miss_cnt(ld_miss_cnt),
        .st_hit_cnt(st_hit_cnt), .st_miss_cnt(st_miss_cnt)
    );

    mem_wb_seg_reg #(.DATA_W(64), .CNT_W(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clear(1'b0),
        .addr_m(w_addr_m), .wdata_m(w_wdata_m), .we_m(w_we_m),
        .mem_to_reg_m(w_mem_to_reg_m), .result_m(w_result_m), .rd_m(5'd0),
        .reg_write_m(3'd0), .result_w(w_result_w), .rd_w(w_rd_w),
        .reg_write_w(w_reg_write_w), .mem_to_reg_w(w_mem_to_reg_w),
        .byte_sel_w(w_byte_sel_w), .rd_data_w(w_rd_data_w),
        .cache_addr(w_cache_addr), .cache_rd_req(w_cache_rd_req),
        .cache_wr_req(w_cache_wr_req), .cache_wr_data(w_cache_wr_data),
        .cache_rd_data(w_cache_rd_data), .cache_miss(w_cache_miss),
        .stall_req(w_stall_req), .cnt_clr(w_cnt_clr),
        .ld_hit_cnt(w_ld_hit_cnt), .ld_miss_cnt(w_ld_miss_cnt),
        .st_hit_cnt(w_st_hit_cnt), .st_miss_cnt(w_st_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main;
        mem_to_reg_m = 1'b0;
        we_m         = '0;
        cache_miss   = 1'b0;
    endtask

    initial begin
        // ---------------- reset with every input high ----------------
        rst_n = 1'b0;
        en = 1'b1; clear = 1'b1; mem_to_reg_m = 1'b1; cache_miss = 1'b1;
        cnt_clr = 1'b1; addr_m = '1; wdata_m = '1; result_m = '1;
        cache_rd_data = '1; we_m = '1; rd_m = '1; reg_write_m = '1;
        w_mem_to_reg_m = 1'b0; w_cache_miss = 1'b0; w_cnt_clr = 1'b0;
        w_addr_m = '0; w_wdata_m = '0; w_result_m = '0;
        w_cache_rd_data = '0; w_we_m = '0;
        #12;
        check("rst result_w", result_w, 0);
        check("rst rd_w", rd_w, 0);
        check("rst reg_write_w", reg_write_w, 0);
        check("rst mem_to_reg_w", mem_to_reg_w, 0);
        check("rst byte_sel_w", byte_sel_w, 0);
        check("rst ld_hit", ld_hit_cnt, 0);
        check("rst ld_miss", ld_miss_cnt, 0);
        check("rst st_hit", st_hit_cnt, 0);
        check("rst st_miss", st_miss_cnt, 0);
        check("rst stall_req high", stall_req, 1);
        cache_miss = 1'b0;
        #1;
        check("rst stall_req low", stall_req, 0);

        // ---------------- release, first transfer ----------------
        clear = 1'b0; cnt_clr = 1'b0; idle_main();
        addr_m = 32'h0; wdata_m = 32'h0; result_m = 32'h1234;
        rd_m = 5'd5; reg_write_m = 3'd3; cache_rd_data = 32'h0;
        #1;
        rst_n = 1'b1;
        tick();
        check("first result_w", result_w, 32'h1234);
        check("first rd_w", rd_w, 5);
        check("first reg_write_w", reg_write_w, 3);

        // ---------------- stall / flush data path ----------------
        mem_to_reg_m = 1'b1; addr_m = 32'h202; result_m = 32'hAAAA;
        rd_m = 5'd7; reg_write_m = 3'd1;
        tick();
        check("load mem_to_reg_w", mem_to_reg_w, 1);
        check("load byte_sel_w", byte_sel_w, 2);
        check("load ld_hit", ld_hit_cnt, 1);
        mem_to_reg_m = 1'b0; cache_rd_data = 32'hDEADBEEF; en = 1'b0;
        result_m = 32'hBBBB; rd_m = 5'd9;
        #1;
        check("load rd_data_w", rd_data_w, 32'hDEADBEEF);
        tick();
        cache_rd_data = 32'h0;
        #1;
        check("stall1 rd_data_w", rd_data_w, 32'hDEADBEEF);
        check("stall1 result_w", result_w, 32'hAAAA);
        tick();
        check("stall2 rd_data_w", rd_data_w, 32'hDEADBEEF);
        clear = 1'b1;
        tick();
        check("stall3 clear ignored rd_data_w", rd_data_w, 32'hDEADBEEF);
        check("stall3 clear ignored result_w", result_w, 32'hAAAA);
        check("stall3 clear ignored rd_w", rd_w, 7);
        check("stall3 clear ignored mem_to_reg_w", mem_to_reg_w, 1);
        check("stall3 clear ignored byte_sel_w", byte_sel_w, 2);
        en = 1'b1; cache_rd_data = 32'h55;
        tick();
        check("flush rd_data_w", rd_data_w, 0);
        check("flush result_w", result_w, 0);
        check("flush rd_w", rd_w, 0);
        check("flush reg_write_w", reg_write_w, 0);
        check("flush mem_to_reg_w", mem_to_reg_w, 0);
        check("flush byte_sel_w", byte_sel_w, 0);
        check("flush keeps ld_hit", ld_hit_cnt, 1);
        clear = 1'b0; result_m = 32'h9; rd_m = 5'd1;
        tick();
        check("post flush rd_data_w", rd_data_w, 32'h55);
        check("post flush result_w", result_w, 32'h9);

        // ---------------- counter clear ----------------
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr ld_hit", ld_hit_cnt, 0);

        // ---------------- miss episode ----------------
        mem_to_reg_m = 1'b1; addr_m = 32'h100; cache_miss = 1'b1; en = 1'b0;
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                cache_miss = 1'b0;
                en = 1'b1;
            end
            #1;
            if (stall_req) stall_cycles++;
            tick();
        end
        check("miss stall cycles", stall_cycles, 4);
        check("miss ld_miss", ld_miss_cnt, 1);
        check("miss ld_hit", ld_hit_cnt, 0);
        idle_main();
        tick();

        // ---------------- de-duplication ----------------
        mem_to_reg_m = 1'b1; addr_m = 32'h100;
        #1;
        check("dedup cache_rd_req", cache_rd_req, 1);
        check("dedup cache_addr", cache_addr, 32'h100);
        tick();
        tick();
        idle_main();
        tick();
        mem_to_reg_m = 1'b1;
        tick();
        mem_to_reg_m = 1'b0; we_m = 4'b0001; wdata_m = 32'hCAFE0001;
        #1;
        check("dedup cache_wr_req", cache_wr_req, 1);
        check("dedup cache_wr_data", cache_wr_data, 32'hCAFE0001);
        tick();
        idle_main();
        tick();
        check("dedup ld_hit", ld_hit_cnt, 2);
        check("dedup st_hit", st_hit_cnt, 1);
        check("dedup ld_miss", ld_miss_cnt, 1);

        // store miss, then load+store together at a new address
        we_m = 4'b1100; addr_m = 32'h104; cache_miss = 1'b1;
        #1;
        check("store stall_req", stall_req, 1);
        tick();
        tick();
        check("store st_miss", st_miss_cnt, 1);
        cache_miss = 1'b0; mem_to_reg_m = 1'b1; we_m = 4'hF; addr_m = 32'h108;
        tick();
        check("both ld_hit", ld_hit_cnt, 3);
        check("both st_hit", st_hit_cnt, 1);
        idle_main();
        tick();

        // ---------------- reset mid-miss ----------------
        mem_to_reg_m = 1'b1; addr_m = 32'h300; cache_miss = 1'b1;
        tick();
        check("premiss ld_miss", ld_miss_cnt, 2);
        rst_n = 1'b0;
        #1;
        check("async rst ld_miss", ld_miss_cnt, 0);
        check("async rst ld_hit", ld_hit_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("after rst ld_miss", ld_miss_cnt, 1);
        tick();
        check("after rst no recount", ld_miss_cnt, 1);
        idle_main();
        tick();

        // ---------------- 64-bit, 4-bit counter instance ----------------
        w_we_m = 8'h80; w_addr_m = 32'h1007; w_wdata_m = 64'h0123456789ABCDEF;
        #1;
        check("w cache_wr_req", w_cache_wr_req, 1);
        check("w cache_wr_data", w_cache_wr_data, 64'h0123456789ABCDEF);
        tick();
        check("w byte_sel_w", w_byte_sel_w, 3'd7);
        check("w st_hit", w_st_hit_cnt, 1);
        w_we_m = '0; w_mem_to_reg_m = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w_addr_m = 32'h2000 + 32'(i * 8);
            tick();
            if (i == 14) check("w ld_hit at 15", w_ld_hit_cnt, 15);
        end
        check("w ld_hit saturated", w_ld_hit_cnt, 15);
        w_cnt_clr = 1'b1; w_addr_m = 32'h3000;
        tick();
        check("w clr ld_hit", w_ld_hit_cnt, 0);
        check("w clr st_hit", w_st_hit_cnt, 0);
        w_cnt_clr = 1'b0; w_addr_m = 32'h3008;
        tick();
        check("w after clr ld_hit", w_ld_hit_cnt, 1);
        w_mem_to_reg_m = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_seg_reg.md
# mem_wb_seg_reg

Parametrised MEM/WB segment register for the five-stage RISC-V core. It registers the MEM-stage control and result fields into WB, supports stall and flush, and drives the data-cache request interface. It applies stall/flush semantics to the one-cycle-latency cache read data and raises a pipeline stall request while the cache reports a miss. It adds per-type (load/store) hit and miss counters with correct per-access de-duplication, saturation and software clear.

## Interface

Parameters:
- DATA_W, 32, data/result width; must be a multiple of 8
- ADDR_W, 32, byte-address width
- REG_W, 5, register index width
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  segment enable; 0 = stall (hold all WB state)
- clear  in  1  synchronous flush; effective only when en=1
- addr_m  in  ADDR_W  MEM-stage byte address
- wdata_m  in  DATA_W  store data
- we_m  in  DATA_W/8  per-byte write enables
- mem_to_reg_m  in  1  load request
- result_m  in  DATA_W  ALU result
- rd_m  in  REG_W  destination register
- reg_write_m  in  3  register-write type code
- result_w  out  DATA_W  registered result
- rd_w  out  REG_W  registered destination
- reg_write_w  out  3  registered write type
- mem_to_reg_w  out  1  registered load flag
- byte_sel_w  out  log2(DATA_W/8)  registered addr_m low bits, used for load extension
- rd_data_w  out  DATA_W  load data presented to WB
- cache_addr  out  ADDR_W  equals addr_m (combinational)
- cache_rd_req  out  1  equals mem_to_reg_m
- cache_wr_req  out  1  OR-reduction of we_m
- cache_wr_data  out  DATA_W  equals wdata_m
- cache_rd_data  in  DATA_W  cache read data, valid one cycle after request
- cache_miss  in  1  cache miss/busy for the current request
- stall_req  out  1  (cache_rd_req | cache_wr_req) & cache_miss, combinational
- cnt_clr  in  1  synchronous clear of all counters
- ld_hit_cnt, ld_miss_cnt, st_hit_cnt, st_miss_cnt  out  CNT_W  performance counters

## Operation

- Reset (rst_n=0): all registered outputs and counters are 0; internal stall_ff, clear_ff, rd_old and last-access tracking are 0.
- Segment register, each edge:
  - en=1, clear=0: load the *_m fields; byte_sel_w takes addr_m[log2(DATA_W/8)-1:0].
  - en=1, clear=1: all WB fields become 0.
  - en=0: hold; clear is ignored.
- Read-data path:
  - stall_ff <= ~en; clear_ff <= clear & en; rd_old <= rd_data_w.
  - rd_data_w = stall_ff ? rd_old : clear_ff ? 0 : cache_rd_data.
- Access episode. An access is active when cache_rd_req | cache_wr_req. The access type is load if cache_rd_req, else store; load wins if both are asserted. A new episode starts on a cycle where an access is active and any of these holds:
  - no access was active in the previous cycle;
  - addr_m differs from the last recorded address;
  - the type differs from the last recorded type.
- Tracking registers:
  - last address/type are recorded on every active cycle;
  - prev_active is recorded every cycle.
  - Consecutive back-to-back accesses to the same address are therefore counted once per episode; separated accesses to the same address count again.
- Counting is done only at episode start:
  - cache_miss=1 increments the miss counter of that type;
  - otherwise the hit counter of that type is incremented.
  - Counters saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- Counters and tracking are unaffected by clear; pipeline flush does not reset statistics.

## Timing

- WB fields: one-cycle latency from *_m when en=1.
- rd_data_w: valid the cycle after the load is in MEM, aligned with mem_to_reg_w.
- stall_req and cache_* outputs are combinational from MEM inputs, with no added latency.
- A miss held for N cycles produces N cycles of stall_req and exactly one miss count.
- rst_n deasserted mid-miss: counters restart at 0. The in-flight access is counted as a new episode on the first active cycle after reset.
- Counter increment is visible the cycle after episode start.

## Test plan

- Reset: rst_n=0 with all inputs at 1 -> every output 0, and stall_req follows its inputs combinationally. Release reset -> first load of result_m=0x1234 appears on result_w after 1 edge.
- Stall/flush data: load returns 0xDEADBEEF, then en=0 for 3 cycles while cache_rd_data changes to 0x0 -> rd_data_w holds 0xDEADBEEF. Next, en=1 with clear=1 -> rd_data_w=0 for one cycle and WB fields are 0.
- clear while en=0 -> no change to any WB output.
- Miss episode: load at 0x100 with cache_miss=1 for 4 cycles, then 0 -> stall_req high for exactly 4 cycles, ld_miss_cnt=1, ld_hit_cnt=0.
- De-duplication: loads to 0x100, 0x100 (back-to-back), idle, 0x100, then a store to 0x100, all hits -> ld_hit_cnt=2, st_hit_cnt=1.
- Saturation/clear: CNT_W=4 with 20 distinct hit loads -> ld_hit_cnt=15. cnt_clr asserted together with a hit -> 0 next cycle.
- Width parametrisation: DATA_W=64 -> we_m is 8 bits, byte_sel_w is 3 bits. A store with we_m=8'h80 asserts cache_wr_req, and st counter behaviour is as above.
